dmem_io_ctrl: RTL and testbench
===============================

Name: dmem_io_ctrl

Overview:
Data-side memory and I/O controller directly downstream of the single-cycle ARM core's data port. It consumes ALUResult (address), WriteData and MemWrite, and returns ReadData in the same cycle. It decodes the address into a word RAM and a small memory-mapped I/O page: a free-running timer, a byte transmit FIFO with valid/ready drain, and a status register.

Parameters:
RAM_WORDS, 64, number of 32-bit RAM words (power of 2)
FIFO_DEPTH, 4, TX FIFO entries (power of 2, ≥2)
IO_BASE, 32'h8000_0000, base byte address of I/O page

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
addr  input  32  byte address from core ALUResult
wdata  input  32  store data from core WriteData
mem_write  input  1  store strobe from core MemWrite
rdata  output  32  load data to core ReadData, combinational
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  consumer accepts head byte this cycle
bus_err  output  1  registered one-cycle pulse on access to unmapped address

Behaviour:
- Reset (reset=0, async): timer=0, FIFO empty (rd/wr ptrs and count 0), overflow flag=0, bus_err=0, tx_valid=0, tx_data=0. RAM contents not reset.
- addr[1:0] ignored; all accesses word-wide.
- Decode:
  - RAM: addr < RAM_WORDS*4. Index addr[log2(RAM_WORDS)+1:2].
  - TIMER: IO_BASE+0.
  - TXDATA: IO_BASE+4.
  - STATUS: IO_BASE+8.
  - Anything else unmapped.
- Loads: rdata is combinational from addr, valid in the same cycle (zero latency), consistent with the single-cycle core.
  - RAM → word.
  - TIMER → current count.
  - TXDATA → 0.
  - STATUS → {16'b0, count[7:0], 5'b0, overflow, empty, full}, with count zero-extended.
  - Unmapped → 0.
- Stores (mem_write=1), applied at the rising edge:
  - RAM: word written. A load in the same cycle returns the old value.
  - TIMER: timer ← wdata. The load takes priority over the increment.
  - TXDATA: push wdata[7:0].
  - STATUS: any write clears overflow; other bits read-only.
  - Unmapped: no state change.
- Timer: +1 every cycle when not being written; wraps 0xFFFF_FFFF→0.
- FIFO:
  - pop occurs when tx_valid & tx_ready.
  - push is accepted if !full, or if full with a pop in the same cycle.
  - A push to a full FIFO with no pop is dropped and sets overflow (sticky).
  - Push and pop in the same cycle leave count unchanged.
  - A push to an empty FIFO makes tx_valid=1 on the next cycle; there is no bypass.
  - tx_data = head entry; it is 0 or stale when empty and is only meaningful while tx_valid=1.
  - Pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH.
  - full = (count==FIFO_DEPTH); empty = (count==0).
- bus_err: asserted for exactly the cycle after any load-address or store to an unmapped address.
  - Loads are not qualified, because the core always drives addr. The decode reports only when mem_write=1 or when addr lies within [IO_BASE, IO_BASE+0xFFF] but is unmapped.
  - A store to an unmapped RAM-range address (≥RAM_WORDS*4, below IO_BASE) also pulses bus_err.
- Reset mid-operation: FIFO contents are discarded, and tx_valid falls immediately (async).

Test Plan:
- Reset then idle 5 cycles → TIMER load returns 5 (±0 relative to the release edge); tx_valid=0; STATUS=0x0000_0002.
- Store 0xDEADBEEF to addr 0x10, load 0x10 next cycle → rdata=0xDEADBEEF. Load 0x13 → same word.
- Store TIMER=0xFFFF_FFFE, then read on consecutive cycles → 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- With tx_ready=0, push bytes 0x41..0x45 (5 pushes, depth 4):
  - STATUS=0x0000_0405 (count 4, overflow, full).
  - Raise tx_ready → tx_data 0x41,0x42,0x43,0x44 on successive cycles, then tx_valid=0.
  - Store to STATUS → overflow cleared.
- FIFO full with tx_ready=1 and a same-cycle push of 0x55 → no overflow, count stays 4; 0x55 is drained last.
- Store to IO_BASE+0x20 → bus_err=1 for one cycle; no state change; load returns 0. Assert reset while FIFO holds 2 bytes → tx_valid=0 immediately, STATUS empty after release.

Source files
------------

// File: rtl/dmem_io_ctrl.sv
// Data-side memory/IO controller for the single-cycle core: word RAM plus an IO page holding
// a free-running timer, a byte TX FIFO with valid/ready drain, and a status register.
module dmem_io_ctrl #(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] IO_BASE    = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);
    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [31:0]   r_ram [RAM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [31:0]   r_timer;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_bus_err;

    logic [31:0]   w_io_off;
    logic          w_in_page;
    logic          w_sel_ram;
    logic          w_sel_timer;
    logic          w_sel_txdata;
    logic          w_sel_status;
    logic          w_mapped;
    logic          w_err_d;
    logic [AW-1:0] w_ram_idx;
    logic          w_full;
    logic          w_empty;
    logic          w_push_req;
    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_status;

    // Offset within the IO page; addr[1:0] is dropped by comparing word offsets only.
    assign w_io_off     = addr - IO_BASE;
    assign w_in_page    = (addr >= IO_BASE) && (w_io_off[31:12] == '0);
    assign w_sel_ram    = (addr[31:AW+2] == '0);
    assign w_sel_timer  = w_in_page && (w_io_off[11:2] == 10'd0);
    assign w_sel_txdata = w_in_page && (w_io_off[11:2] == 10'd1);
    assign w_sel_status = w_in_page && (w_io_off[11:2] == 10'd2);
    assign w_mapped     = w_sel_ram | w_sel_timer | w_sel_txdata | w_sel_status;
    assign w_err_d      = !w_mapped && (mem_write || w_in_page);
    assign w_ram_idx    = addr[AW+1:2];

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && tx_ready;
    assign w_push_req = mem_write && w_sel_txdata;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_status   = {16'b0, 8'(r_count), 5'b0, r_overflow, w_empty, w_full};

    assign tx_valid = !w_empty;
    assign tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign bus_err  = r_bus_err;

    always_comb begin
        rdata = '0;
        if (w_sel_ram) begin
            rdata = r_ram[w_ram_idx];
        end else if (w_sel_timer) begin
            rdata = r_timer;
        end else if (w_sel_status) begin
            rdata = w_status;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_write && w_sel_ram) begin
            r_ram[w_ram_idx] <= wdata;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_timer   <= (mem_write && w_sel_timer) ? wdata : r_timer + 32'd1;
            r_bus_err <= w_err_d;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (mem_write && w_sel_status) begin
                r_overflow <= 1'b0;
            end else if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_io_ctrl.sv
// Self-checking bench for dmem_io_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model built from arrays, a byte queue and plain counters.
module tb_dmem_io_ctrl;
    localparam int unsigned RAM_WORDS  = 64;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [31:0] IO_BASE    = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_write = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_ram [RAM_WORDS];
    logic [31:0] m_timer = '0;
    logic [7:0]  m_q[$];
    logic        m_ovf = 1'b0;
    logic        m_err = 1'b0;

    dmem_io_ctrl #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .IO_BASE   (IO_BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .mem_write(mem_write),
        .rdata    (rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timed out");
    end

    function automatic bit in_page(input logic [31:0] a);
        return (a >= IO_BASE) && (a <= IO_BASE + 32'hFFF);
    endfunction

    function automatic bit is_mapped(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w < 32'(RAM_WORDS * 4)) || (w == IO_BASE) || (w == IO_BASE + 32'd4)
            || (w == IO_BASE + 32'd8);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        logic [31:0] w;
        int n;
        w = {a[31:2], 2'b00};
        n = m_q.size();
        if (w < 32'(RAM_WORDS * 4)) return m_ram[w[7:2]];
        if (w == IO_BASE) return m_timer;
        if (w == IO_BASE + 32'd8)
            return {16'b0, 8'(n), 5'b0, m_ovf, 1'(n == 0), 1'(n == FIFO_DEPTH)};
        return 32'h0;
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        logic [31:0] w;
        int n;
        bit pop;
        w = {addr[31:2], 2'b00};
        n = m_q.size();
        pop = (n != 0) && tx_ready;
        m_err = !is_mapped(addr) && (mem_write || in_page(addr));
        if (pop) void'(m_q.pop_front());
        if (mem_write && w == IO_BASE + 32'd4) begin
            if (n < FIFO_DEPTH || pop) m_q.push_back(wdata[7:0]);
            else m_ovf = 1'b1;
        end
        if (mem_write && w == IO_BASE + 32'd8) m_ovf = 1'b0;
        if (mem_write && w == IO_BASE) m_timer = wdata;
        else m_timer = m_timer + 32'd1;
        if (mem_write && w < 32'(RAM_WORDS * 4)) m_ram[w[7:2]] = wdata;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        m_timer = '0;
        m_q.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic fifo_clean();
        mem_write = 1'b0;
        tx_ready = 1'b1;
        addr = '0;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) cycle();
        tx_ready = 1'b0;
        mem_write = 1'b1;
        addr = IO_BASE + 32'd8;
        cycle();
        mem_write = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        addr = IO_BASE + 32'd4;
        wdata = {24'hABCDEF, b};
        mem_write = 1'b1;
        cycle();
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        addr = '0;
        mem_write = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        #1;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid);
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx_data got %h want 00", tx_data);
        end
        checks++;
        if (bus_err !== 1'b0) begin
            errors++; $display("FAIL reset_bus_err got %b want 0", bus_err);
        end
        addr = IO_BASE;
        #1;
        checks++;
        if (rdata !== 32'd5) begin
            errors++; $display("FAIL reset_timer got %h want 00000005", rdata);
        end
        addr = IO_BASE + 32'd8;
        #1;
        checks++;
        if (rdata !== 32'h0000_0002) begin
            errors++; $display("FAIL reset_status got %h want 00000002", rdata);
        end
    endtask

    task automatic preload_ram();
        mem_write = 1'b1;
        for (int i = 0; i < RAM_WORDS; i++) begin
            addr = 32'(i * 4);
            wdata = $urandom();
            cycle();
        end
        mem_write = 1'b0;
    endtask

    task automatic test_ram();
        logic [31:0] old;
        old = m_ram[4];
        addr = 32'h10;
        wdata = 32'hDEAD_BEEF;
        mem_write = 1'b1;
        #1;
        checks++;
        if (rdata !== old) begin
            errors++; $display("FAIL ram_same_cycle_old got %h want %h", rdata, old);
        end
        cycle();
        mem_write = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_readback got %h want deadbeef", rdata);
        end
        addr = 32'h13;
        #1;
        checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_unaligned got %h want deadbeef", rdata);
        end
    endtask

    task automatic test_timer_wrap();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hFFFF_FFFE;
        exp_seq[1] = 32'hFFFF_FFFF;
        exp_seq[2] = 32'h0000_0000;
        addr = IO_BASE;
        wdata = 32'hFFFF_FFFE;
        mem_write = 1'b1;
        cycle();
        mem_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rdata !== exp_seq[i]) begin
                errors++; $display("FAIL timer_wrap[%0d] got %h want %h", i, rdata, exp_seq[i]);
            end
            cycle();
        end
    endtask

    task automatic test_fifo_overflow();
        fifo_clean();
        for (int i = 0; i < 5; i++) push_byte(8'(8'h41 + i));
        addr = IO_BASE + 32'd8;
        #1;
        checks++;
        if (rdata !== 32'h0000_0405) begin
            errors++; $display("FAIL ovf_status got %h want 00000405", rdata);
        end
        addr = '0;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
                errors++;
                $display("FAIL ovf_drain[%0d] got v=%b d=%h want v=1 d=%h", i, tx_valid,
                         tx_data, 8'(8'h41 + i));
            end
            cycle();
        end
        #1;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_drained_valid got %b want 0", tx_valid);
        end
        tx_ready = 1'b0;
        addr = IO_BASE + 32'd8;
        wdata = $urandom();
        mem_write = 1'b1;
        cycle();
        mem_write = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'h0000_0002) begin
            errors++; $display("FAIL ovf_clear got %h want 00000002", rdata);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h62; exp_seq[1] = 8'h63; exp_seq[2] = 8'h64; exp_seq[3] = 8'h55;
        fifo_clean();
        for (int i = 0; i < 4; i++) push_byte(8'(8'h61 + i));
        addr = IO_BASE + 32'd4;
        wdata = 32'h0000_0055;
        mem_write = 1'b1;
        tx_ready = 1'b1;
        #1;
        checks++;
        if (tx_data !== 8'h61) begin
            errors++; $display("FAIL fpp_head got %h want 61", tx_data);
        end
        cycle();
        mem_write = 1'b0;
        tx_ready = 1'b0;
        addr = IO_BASE + 32'd8;
        #1;
        checks++;
        if (rdata !== 32'h0000_0401) begin
            errors++; $display("FAIL fpp_status got %h want 00000401", rdata);
        end
        addr = '0;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_seq[i]) begin
                errors++;
                $display("FAIL fpp_drain[%0d] got v=%b d=%h want v=1 d=%h", i, tx_valid,
                         tx_data, exp_seq[i]);
            end
            cycle();
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_bus_err();
        addr = IO_BASE + 32'h20;
        wdata = $urandom();
        mem_write = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL berr_rdata got %h want 00000000", rdata);
        end
        cycle();
        mem_write = 1'b0;
        addr = 32'h10;
        #1;
        checks++;
        if (bus_err !== 1'b1) begin
            errors++; $display("FAIL berr_pulse got %b want 1", bus_err);
        end
        checks++;
        if (rdata !== exp_rdata(addr)) begin
            errors++; $display("FAIL berr_ram got %h want %h", rdata, exp_rdata(addr));
        end
        cycle();
        addr = IO_BASE + 32'd8;
        #1;
        checks++;
        if (bus_err !== 1'b0) begin
            errors++; $display("FAIL berr_one_cycle got %b want 0", bus_err);
        end
        checks++;
        if (rdata !== exp_rdata(addr)) begin
            errors++; $display("FAIL berr_status got %h want %h", rdata, exp_rdata(addr));
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0, 1:    return 32'($urandom_range(0, RAM_WORDS * 4 - 1));
            2:       return IO_BASE + 32'($urandom_range(0, 3));
            3:       return IO_BASE + 32'd4 + 32'($urandom_range(0, 3));
            4:       return IO_BASE + 32'd8 + 32'($urandom_range(0, 3));
            5:       return IO_BASE + 32'($urandom_range(12, 4095));
            6:       return 32'($urandom_range(RAM_WORDS * 4, 32'h7FFF_FFFF));
            default: return $urandom();
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] e;
        for (int i = 0; i < 300; i++) begin
            addr = rand_addr();
            wdata = $urandom();
            mem_write = ($urandom_range(0, 2) == 0);
            tx_ready = ($urandom_range(0, 2) != 0);
            #1;
            e = exp_rdata(addr);
            checks++;
            if (rdata !== e) begin
                errors++; $display("FAIL rnd_rdata[%0d] addr=%h got %h want %h", i, addr, rdata, e);
            end
            cycle();
            checks++;
            if (bus_err !== m_err) begin
                errors++; $display("FAIL rnd_bus_err[%0d] got %b want %b", i, bus_err, m_err);
            end
            checks++;
            if (tx_valid !== (m_q.size() != 0)) begin
                errors++;
                $display("FAIL rnd_tx_valid[%0d] got %b want %b", i, tx_valid, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if (tx_data !== m_q[0]) begin
                    errors++; $display("FAIL rnd_tx_data[%0d] got %h want %h", i, tx_data, m_q[0]);
                end
            end
        end
        mem_write = 1'b0;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        fifo_clean();
        push_byte(8'hA1);
        push_byte(8'hA2);
        addr = '0;
        #1;
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_pre_valid got %b want 1", tx_valid);
        end
        #1;
        reset = 1'b0;
        m_timer = '0;
        m_q.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_async_valid got %b want 0", tx_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        addr = IO_BASE + 32'd8;
        #1;
        checks++;
        if (rdata !== 32'h0000_0002) begin
            errors++; $display("FAIL midrst_status got %h want 00000002", rdata);
        end
    endtask

    initial begin
        test_reset();
        preload_ram();
        test_ram();
        test_timer_wrap();
        test_fifo_overflow();
        test_full_push_pop();
        test_bus_err();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
